serdesphy_pll_lock_ctrl: RTL and testbench

SERDESPHY_PLL_LOCK_CTRL -- requirements
Module: serdesphy_pll_lock_ctrl

---
 rtl/serdesphy_pll_lock_ctrl_if.sv | 28 ++
 rtl/serdesphy_pll_lock_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_serdesphy_pll_lock_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/serdesphy_pll_lock_ctrl_if.sv
// Control/status bundle between the PLL lock controller and its host.
// The master side drives enables and strobes; the slave side is the controller.
interface serdesphy_pll_lock_ctrl_if #(
  parameter int CNT_W = 10
);
  logic             enable;
  logic             pll_bypass;
  logic             vco_ready;
  logic             fb_pulse;
  logic             clr_sticky;
  logic             pll_rst_req;
  logic             pll_lock;
  logic             lost_lock;
  logic             lock_fail;
  logic [2:0]       state;
  logic [CNT_W-1:0] last_count;
  logic [1:0]       retry_cnt;

  modport master (
    output enable, pll_bypass, vco_ready, fb_pulse, clr_sticky,
    input  pll_rst_req, pll_lock, lost_lock, lock_fail, state, last_count, retry_cnt
  );

  modport slave (
    input  enable, pll_bypass, vco_ready, fb_pulse, clr_sticky,
    output pll_rst_req, pll_lock, lost_lock, lock_fail, state, last_count, retry_cnt
  );
endinterface

// File: rtl/serdesphy_pll_lock_ctrl.sv
// PLL lock controller: resets the PLL, waits for the VCO, then counts feedback
// pulses per reference window to declare, hold and drop lock with bounded retries.
module serdesphy_pll_lock_ctrl #(
  parameter int WIN_LEN      = 256,
  parameter int CNT_W        = 10,
  parameter int EXPECT       = 128,
  parameter int TOL          = 4,
  parameter int LOCK_WINS    = 4,
  parameter int UNLOCK_WINS  = 2,
  parameter int TIMEOUT_WINS = 64,
  parameter int MAX_RETRY    = 3,
  parameter int RST_LEN      = 16
) (
  input  logic                    clk_ref_24m,
  input  logic                    rst,
  serdesphy_pll_lock_ctrl_if.slave bus
);
  localparam int RUN_W = $clog2(((LOCK_WINS > UNLOCK_WINS) ? LOCK_WINS : UNLOCK_WINS) + 1);
  localparam int TMO_W = $clog2(TIMEOUT_WINS + 1);
  localparam int RST_W = $clog2(RST_LEN + 1);
  localparam int CW1   = CNT_W + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_PLL  = 3'd1,
    WAIT_VCO = 3'd2,
    ACQUIRE  = 3'd3,
    LOCKED   = 3'd4,
    FAIL     = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] fb_cnt_q, fb_cnt_d;
  logic [CNT_W-1:0] last_count_q, last_count_d;
  logic [RUN_W-1:0] good_run_q, good_run_d;
  logic [RUN_W-1:0] bad_run_q, bad_run_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]       retry_cnt_q, retry_cnt_d;
  logic             pll_lock_q, pll_lock_d;
  logic             pll_rst_req_q, pll_rst_req_d;
  logic             lost_lock_q, lost_lock_d;
  logic             lock_fail_q, lock_fail_d;

  logic             go;
  logic             win_end;
  logic             win_good;
  logic             lost_set;
  logic             fail_set;
  logic [CNT_W-1:0] fb_inc;
  logic [CW1-1:0]   cnt_ext;
  logic [CW1-1:0]   diff;
  logic [RUN_W-1:0] good_n;
  logic [RUN_W-1:0] bad_n;

  assign go      = bus.enable && !bus.pll_bypass;
  assign win_end = (win_cnt_q == CNT_W'(WIN_LEN - 1));
  // Saturating count including a strobe on the current (possibly last) window cycle.
  assign fb_inc  = (bus.fb_pulse && (fb_cnt_q != '1)) ? fb_cnt_q + 1'b1 : fb_cnt_q;
  assign cnt_ext = {1'b0, fb_inc};
  assign diff    = (cnt_ext >= CW1'(EXPECT)) ? cnt_ext - CW1'(EXPECT) : CW1'(EXPECT) - cnt_ext;
  assign win_good = (diff <= CW1'(TOL));
  assign good_n  = win_good ? good_run_q + 1'b1 : '0;
  assign bad_n   = win_good ? '0 : bad_run_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    win_cnt_d    = win_cnt_q;
    fb_cnt_d     = fb_cnt_q;
    last_count_d = last_count_q;
    good_run_d   = good_run_q;
    bad_run_d    = bad_run_q;
    tmo_cnt_d    = tmo_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    lost_set     = 1'b0;
    fail_set     = 1'b0;

    if ((state_q == ACQUIRE) || (state_q == LOCKED)) begin
      win_cnt_d = win_end ? '0 : win_cnt_q + 1'b1;
      fb_cnt_d  = win_end ? '0 : fb_inc;
      if (win_end) last_count_d = fb_inc;
    end

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d     = RST_PLL;
          retry_cnt_d = '0;
          rst_cnt_d   = '0;
        end
      end
      RST_PLL: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RST_W'(RST_LEN - 1)) state_d = WAIT_VCO;
      end
      WAIT_VCO: begin
        if (bus.vco_ready) begin
          state_d    = ACQUIRE;
          win_cnt_d  = '0;
          fb_cnt_d   = '0;
          good_run_d = '0;
          bad_run_d  = '0;
          tmo_cnt_d  = '0;
        end
      end
      ACQUIRE: begin
        if (!bus.vco_ready) begin
          state_d = WAIT_VCO;
        end else if (win_end) begin
          good_run_d = good_n;
          // Lock is tested before timeout so a window satisfying both locks.
          if (good_n >= RUN_W'(LOCK_WINS)) begin
            state_d   = LOCKED;
            bad_run_d = '0;
          end else if (tmo_cnt_q == TMO_W'(TIMEOUT_WINS - 1)) begin
            if (retry_cnt_q < 2'(MAX_RETRY)) begin
              state_d     = RST_PLL;
              retry_cnt_d = retry_cnt_q + 1'b1;
              rst_cnt_d   = '0;
              good_run_d  = '0;
              tmo_cnt_d   = '0;
            end else begin
              state_d  = FAIL;
              fail_set = 1'b1;
            end
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (!bus.vco_ready) begin
          state_d  = WAIT_VCO;
          lost_set = 1'b1;
        end else if (win_end) begin
          bad_run_d = bad_n;
          if (bad_n >= RUN_W'(UNLOCK_WINS)) begin
            state_d    = ACQUIRE;
            lost_set   = 1'b1;
            good_run_d = '0;
            bad_run_d  = '0;
            tmo_cnt_d  = '0;
          end
        end
      end
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase

    if (!go) begin
      state_d     = IDLE;
      rst_cnt_d   = '0;
      win_cnt_d   = '0;
      fb_cnt_d    = '0;
      good_run_d  = '0;
      bad_run_d   = '0;
      tmo_cnt_d   = '0;
      retry_cnt_d = '0;
      lost_set    = 1'b0;
      fail_set    = 1'b0;
    end

    // Sticky flags: a set in the same cycle as a clear takes precedence.
    lost_lock_d   = lost_set | (lost_lock_q & ~bus.clr_sticky);
    lock_fail_d   = fail_set | (lock_fail_q & ~bus.clr_sticky);
    pll_lock_d    = (state_d == LOCKED);
    pll_rst_req_d = (state_d == RST_PLL);
  end

  always_ff @(posedge clk_ref_24m) begin
    if (rst) begin
      state_q       <= IDLE;
      rst_cnt_q     <= '0;
      win_cnt_q     <= '0;
      fb_cnt_q      <= '0;
      last_count_q  <= '0;
      good_run_q    <= '0;
      bad_run_q     <= '0;
      tmo_cnt_q     <= '0;
      retry_cnt_q   <= '0;
      pll_lock_q    <= 1'b0;
      pll_rst_req_q <= 1'b0;
      lost_lock_q   <= 1'b0;
      lock_fail_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      win_cnt_q     <= win_cnt_d;
      fb_cnt_q      <= fb_cnt_d;
      last_count_q  <= last_count_d;
      good_run_q    <= good_run_d;
      bad_run_q     <= bad_run_d;
      tmo_cnt_q     <= tmo_cnt_d;
      retry_cnt_q   <= retry_cnt_d;
      pll_lock_q    <= pll_lock_d;
      pll_rst_req_q <= pll_rst_req_d;
      lost_lock_q   <= lost_lock_d;
      lock_fail_q   <= lock_fail_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.pll_lock    = pll_lock_q;
  assign bus.pll_rst_req = pll_rst_req_q;
  assign bus.lost_lock   = lost_lock_q;
  assign bus.lock_fail   = lock_fail_q;
  assign bus.last_count  = last_count_q;
  assign bus.retry_cnt   = retry_cnt_q;
endmodule

// File: tb/tb_serdesphy_pll_lock_ctrl.sv
// Directed bench for the PLL lock controller with 16-cycle windows, expect 8 +/- 1.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_serdesphy_pll_lock_ctrl;
  localparam int WIN = 16;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;
  int   rc;
  bit   ok;

  serdesphy_pll_lock_ctrl_if #(.CNT_W(5)) bus ();

  serdesphy_pll_lock_ctrl #(
    .WIN_LEN(16), .CNT_W(5), .EXPECT(8), .TOL(1), .LOCK_WINS(2), .UNLOCK_WINS(2),
    .TIMEOUT_WINS(4), .MAX_RETRY(1), .RST_LEN(4)
  ) dut (
    .clk_ref_24m(clk),
    .rst        (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // n pulses spread evenly over one window; clr_sticky asserted on cycle clr_at.
  task automatic run_window(input int n, input int clr_at);
    for (int i = 0; i < WIN; i++) begin
      bus.fb_pulse   = ((i * n) % WIN) < n;
      bus.clr_sticky = (i == clr_at);
      step();
    end
    bus.fb_pulse   = 1'b0;
    bus.clr_sticky = 1'b0;
  endtask

  task automatic wait_acquire(output int rst_cycles, output bit reached);
    rst_cycles = 0;
    reached    = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.pll_rst_req) rst_cycles++;
      if (bus.state == 3'd3) begin
        reached = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    clk            = 1'b0;
    rst            = 1'b1;
    bus.enable     = 1'b0;
    bus.pll_bypass = 1'b0;
    bus.vco_ready  = 1'b0;
    bus.fb_pulse   = 1'b0;
    bus.clr_sticky = 1'b0;
    repeat (3) step();
    check("rst_state",      32'(bus.state), 0);
    check("rst_pll_lock",   32'(bus.pll_lock), 0);
    check("rst_rst_req",    32'(bus.pll_rst_req), 0);
    check("rst_lost_lock",  32'(bus.lost_lock), 0);
    check("rst_lock_fail",  32'(bus.lock_fail), 0);
    check("rst_last_count", 32'(bus.last_count), 0);
    check("rst_retry",      32'(bus.retry_cnt), 0);
    rst = 1'b0;
    step();
    check("disabled_idle", 32'(bus.state), 0);

    // Bring-up and lock at 8 pulses per window
    bus.enable    = 1'b1;
    bus.vco_ready = 1'b1;
    wait_acquire(rc, ok);
    check("acq1_reached", 32'(ok), 1);
    check("acq1_rst_len", 32'(rc), 4);
    run_window(8, -1);
    check("w1_last_count", 32'(bus.last_count), 8);
    check("w1_no_lock",    32'(bus.pll_lock), 0);
    run_window(8, -1);
    check("w2_lock",       32'(bus.pll_lock), 1);
    check("w2_state",      32'(bus.state), 4);

    // Drift to 4 pulses per window; clear coincides with the lost_lock set
    run_window(4, -1);
    check("w3_last_count", 32'(bus.last_count), 4);
    check("w3_still_lock", 32'(bus.pll_lock), 1);
    run_window(4, WIN - 1);
    check("unlock_state",  32'(bus.state), 3);
    check("unlock_pll",    32'(bus.pll_lock), 0);
    check("unlock_lost_set_wins", 32'(bus.lost_lock), 1);

    // Persistent count of 10: one retry, then failure
    run_window(10, 0);
    check("clr_lost",       32'(bus.lost_lock), 0);
    check("c10_last_count", 32'(bus.last_count), 10);
    run_window(10, -1);
    run_window(10, -1);
    run_window(10, -1);
    check("tmo1_state", 32'(bus.state), 1);
    check("tmo1_retry", 32'(bus.retry_cnt), 1);
    wait_acquire(rc, ok);
    check("acq2_reached", 32'(ok), 1);
    check("acq2_rst_len", 32'(rc), 4);
    repeat (4) run_window(10, -1);
    check("fail_state",   32'(bus.state), 5);
    check("fail_flag",    32'(bus.lock_fail), 1);
    check("fail_rst_req", 32'(bus.pll_rst_req), 0);
    rc = 0;
    repeat (20) begin
      step();
      if (bus.pll_rst_req) rc++;
    end
    check("fail_no_reset", 32'(rc), 0);
    check("fail_hold",     32'(bus.state), 5);
    bus.clr_sticky = 1'b1;
    step();
    bus.clr_sticky = 1'b0;
    check("clr_fail", 32'(bus.lock_fail), 0);

    // Leave FAIL via disable, then 7,16,9,7: bad window resets the run, lock beats timeout
    bus.enable = 1'b0;
    step();
    check("dis_idle",  32'(bus.state), 0);
    check("dis_retry", 32'(bus.retry_cnt), 0);
    bus.enable = 1'b1;
    wait_acquire(rc, ok);
    check("acq3_reached", 32'(ok), 1);
    run_window(7, -1);
    check("s7_last_count", 32'(bus.last_count), 7);
    run_window(16, -1);
    check("s16_last_count", 32'(bus.last_count), 16);
    check("s16_state",      32'(bus.state), 3);
    run_window(9, -1);
    check("s9_no_lock",  32'(bus.pll_lock), 0);
    check("s9_state",    32'(bus.state), 3);
    run_window(7, -1);
    check("s7b_lock",    32'(bus.pll_lock), 1);
    check("s7b_state",   32'(bus.state), 4);
    check("s7b_retry",   32'(bus.retry_cnt), 0);

    // VCO drop while locked
    bus.vco_ready = 1'b0;
    step();
    check("vco_drop_state", 32'(bus.state), 2);
    check("vco_drop_lock",  32'(bus.pll_lock), 0);
    check("vco_drop_lost",  32'(bus.lost_lock), 1);
    bus.vco_ready = 1'b1;
    step();
    check("vco_back_state", 32'(bus.state), 3);
    run_window(8, -1);
    run_window(8, -1);
    check("relock_state", 32'(bus.state), 4);

    // Bypass while locked, sticky flag holds
    bus.pll_bypass = 1'b1;
    step();
    check("bypass_idle", 32'(bus.state), 0);
    check("bypass_lock", 32'(bus.pll_lock), 0);
    check("bypass_lost_hold", 32'(bus.lost_lock), 1);
    bus.pll_bypass = 1'b0;

    // Synchronous reset mid-window
    wait_acquire(rc, ok);
    check("acq4_reached", 32'(ok), 1);
    repeat (5) begin
      bus.fb_pulse = 1'b1;
      step();
    end
    bus.fb_pulse = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_state", 32'(bus.state), 0);
    check("mid_rst_lost",  32'(bus.lost_lock), 0);
    check("mid_rst_last",  32'(bus.last_count), 0);
    check("mid_rst_lock",  32'(bus.pll_lock), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
